// File: rtl/sc_decoder.sv
// rtl/sc_decoder.sv - stochastic bitstream to binary decoder, N parallel channels
module sc_decoder #(
    parameter int W = 6,
    parameter int N = 2,
    localparam int KW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] k_log2,
    input  logic [N-1:0]  bs_in,
    input  logic          bs_valid,
    output logic          busy,
    output logic [W-1:0]  Bxs [N-1:0],
    output logic          out_valid,
    input  logic          out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [KW-1:0] len;
    logic [W:0]    bit_cnt;
    logic [W:0]    cnt [N-1:0];

    logic [KW-1:0] len_in;
    logic [W:0]    bit_nxt;
    logic [W:0]    target;
    logic [KW-1:0] shift;
    logic [W:0]    cnt_nxt [N-1:0];
    logic [2*W:0]  scaled  [N-1:0];
    logic [W-1:0]  sat_val [N-1:0];

    // Clamp the requested integration length and precompute next counts and the
    // scaled, saturated estimate that would be captured on the final bit.
    always_comb begin
        len_in  = (k_log2 > KW'(W)) ? KW'(W) : k_log2;
        bit_nxt = bit_cnt + 1'b1;
        target  = (W+1)'(1) << len;
        shift   = KW'(W) - len;
        for (int i = 0; i < N; i++) begin
            cnt_nxt[i] = cnt[i] + {{W{1'b0}}, bs_in[i]};
            scaled[i]  = {{W{1'b0}}, cnt_nxt[i]} << shift;
            // Any bit at or above 2^W means the estimate exceeds full scale.
            sat_val[i] = (|scaled[i][2*W:W]) ? {W{1'b1}} : scaled[i][W-1:0];
        end
    end

    // Control FSM with counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
                Bxs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len     <= len_in;
                        bit_cnt <= '0;
                        for (int i = 0; i < N; i++) cnt[i] <= '0;
                        busy    <= 1'b1;
                        state   <= ACC;
                    end
                end
                ACC: begin
                    if (bs_valid) begin
                        bit_cnt <= bit_nxt;
                        for (int i = 0; i < N; i++) cnt[i] <= cnt_nxt[i];
                        if (bit_nxt == target) begin
                            for (int i = 0; i < N; i++) Bxs[i] <= sat_val[i];
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_decoder.sv
// tb/tb_sc_decoder.sv - directed self-checking bench for sc_decoder
module tb_sc_decoder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] k_log2;
    logic [1:0] bs_in;
    logic       bs_valid;
    logic       busy;
    logic [5:0] bxs [1:0];
    logic       out_valid;
    logic       out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    sc_decoder #(.W(6), .N(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_log2    (k_log2),
        .bs_in     (bs_in),
        .bs_valid  (bs_valid),
        .busy      (busy),
        .Bxs       (bxs),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start a conversion and feed nbits valid bits; channel i is one for bit j < ones_i.
    // With gap set, an invalid cycle carrying a start pulse precedes every valid bit.
    task automatic run_vec(input string tag, input int k, input int nbits,
                           input int ones0, input int ones1, input bit gap,
                           input logic [5:0] e0, input logic [5:0] e1, input int exp_cyc);
        int cyc;
        cyc    = 0;
        start  = 1'b1;
        k_log2 = 3'(k);
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int j = 0; j < nbits; j++) begin
            if (gap) begin
                bs_valid = 1'b0;
                bs_in    = 2'b11;
                start    = 1'b1;
                k_log2   = 3'd0;
                @(posedge clk); #1;
                cyc++;
                start = 1'b0;
            end
            bs_valid = 1'b1;
            bs_in    = {(j < ones1), (j < ones0)};
            if (j == nbits - 1) check({tag, "_ov_early"}, 32'(out_valid), 32'd0);
            @(posedge clk); #1;
            cyc++;
            bs_valid = 1'b0;
            bs_in    = 2'b00;
        end
        check({tag, "_ov"}, 32'(out_valid), 32'd1);
        check({tag, "_bxs0"}, 32'(bxs[0]), 32'(e0));
        check({tag, "_bxs1"}, 32'(bxs[1]), 32'(e1));
        check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic ack(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        k_log2    = 3'd0;
        bs_in     = 2'b00;
        bs_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_bxs0", 32'(bxs[0]), 32'd0);
        check("rst_bxs1", 32'(bxs[1]), 32'd0);
        #11;
        rst = 1'b0;

        // Full-length stream, first start right after reset release.
        run_vec("full", 6, 64, 12, 24, 1'b0, 6'b001100, 6'b011000, 64);
        ack("full");

        // Short stream saturating channel 0.
        run_vec("sat", 3, 8, 8, 0, 1'b0, 6'b111111, 6'b000000, 8);

        // Result held while start pulses and bs_in toggles.
        for (int c = 0; c < 10; c++) begin
            start    = 1'b1;
            k_log2   = 3'd1;
            bs_valid = c[0];
            bs_in    = c[0] ? 2'b11 : 2'b10;
            @(posedge clk); #1;
            check("hold_ov", 32'(out_valid), 32'd1);
            check("hold_bxs0", 32'(bxs[0]), 32'd63);
            check("hold_bxs1", 32'(bxs[1]), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        // Start coinciding with the accepting edge is ignored.
        bs_valid  = 1'b0;
        bs_in     = 2'b00;
        start     = 1'b1;
        k_log2    = 3'd0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        out_ready = 1'b0;
        check("rel_ov", 32'(out_valid), 32'd0);
        check("rel_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("rel_no_start", 32'(busy), 32'd0);
        check("rel_bxs0_kept", 32'(bxs[0]), 32'd63);

        // Half-rate valid with start pulses ignored during accumulation.
        run_vec("gap", 6, 64, 32, 0, 1'b1, 6'b100000, 6'b000000, 128);
        ack("gap");

        // Reset in the middle of accumulation.
        start  = 1'b1;
        k_log2 = 3'd6;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j < 20; j++) begin
            bs_valid = 1'b1;
            bs_in    = 2'b11;
            @(posedge clk); #1;
        end
        bs_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ov", 32'(out_valid), 32'd0);
        check("mid_rst_bxs0", 32'(bxs[0]), 32'd0);
        #2;
        rst = 1'b0;
        // Single bit at L=0: 1 << 6 = 64 saturates to 63.
        run_vec("one_bit", 0, 1, 1, 0, 1'b0, 6'b111111, 6'b000000, 1);
        ack("one_bit");

        // Over-range k_log2 clamps to a 64-bit stream.
        run_vec("clamp", 7, 64, 0, 0, 1'b0, 6'b000000, 6'b000000, 64);
        ack("clamp");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
